// File: rtl/uartlite_stream_ctrl.sv
// AXI4-Lite master for a UART Lite core: local TX/RX byte FIFOs with ready/valid streams,
// moved by a single engine that polls STAT and alternates TX/RX transfers.
module uartlite_stream_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int POLL_GAP = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic [7:0]                tx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [7:0]                rx_data,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      rx_overrun,
  output logic                      axi_err,
  input  logic                      err_clr,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [3:0]                axi_awaddr,
  output logic [2:0]                axi_awprot,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  output logic [31:0]               axi_wdata,
  output logic [3:0]                axi_wstrb,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  input  logic [1:0]                axi_bresp,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [3:0]                axi_araddr,
  output logic [2:0]                axi_arprot,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [31:0]               axi_rdata,
  input  logic [1:0]                axi_rresp
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [3:0] ADDR_RX = 4'h0, ADDR_TX = 4'h4, ADDR_STAT = 4'h8;
  // GAP plus the following IDLE cycle together make up the POLL_GAP idle cycles.
  localparam int GAP_LOAD = (POLL_GAP > 1) ? POLL_GAP - 2 : 0;

  typedef enum logic [3:0] {IDLE, ST_AR, ST_R, DECIDE, TX_AW_W, TX_B, RX_AR, RX_R, GAP} state_t;
  localparam state_t AFTER_POLL = (POLL_GAP > 1) ? GAP : IDLE;

  state_t state, state_nxt;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_wr, tx_rd;
  logic           tx_push, tx_pop;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_wr, rx_rd;
  logic           rx_push, rx_pop, rx_full;

  logic       stat_rx, stat_full, aw_done, w_done, prio_rx;
  logic [7:0] gap_cnt;
  logic       can_tx, can_rx, dec_tx, dec_rx, b_err, r_err, stat_ok;
  logic       unused_rdata;

  assign tx_ready = tx_level != (TXW+1)'(TX_DEPTH);
  assign tx_push  = tx_valid && tx_ready;
  assign rx_full  = rx_level == (RXW+1)'(RX_DEPTH);
  assign rx_valid = rx_level != '0;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_mem[rx_rd];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_level <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_level <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TXW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TXW'(1);
      tx_level <= tx_level + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + RXW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RXW'(1);
      rx_level <= rx_level + (RXW+1)'(rx_push) - (RXW+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_data;
    if (rx_push) rx_mem[rx_wr] <= axi_rdata[7:0];
  end

  assign axi_awaddr = ADDR_TX;
  assign axi_awprot = 3'b000;
  assign axi_arprot = 3'b000;
  assign axi_wstrb  = 4'b0001;
  assign axi_wdata  = {24'd0, tx_mem[tx_rd]};

  assign can_tx  = (tx_level != '0) && !stat_full;
  assign can_rx  = stat_rx && !rx_full;
  assign b_err   = axi_bvalid && axi_bready && (axi_bresp != 2'b00);
  assign r_err   = axi_rvalid && axi_rready && (axi_rresp != 2'b00);
  assign stat_ok = (state == ST_R) && axi_rvalid && (axi_rresp == 2'b00);
  assign unused_rdata = ^axi_rdata[31:8];

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_araddr  = ADDR_RX;
    axi_rready  = 1'b0;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    dec_tx      = 1'b0;
    dec_rx      = 1'b0;
    case (state)
      IDLE: if ((tx_level != '0) || !rx_full) state_nxt = ST_AR;
      ST_AR: begin
        axi_arvalid = 1'b1;
        axi_araddr  = ADDR_STAT;
        if (axi_arready) state_nxt = ST_R;
      end
      ST_R: begin
        axi_rready = 1'b1;
        if (axi_rvalid) state_nxt = (axi_rresp != 2'b00) ? AFTER_POLL : DECIDE;
      end
      DECIDE: begin
        if (can_tx && (!prio_rx || !can_rx)) begin
          dec_tx    = 1'b1;
          state_nxt = TX_AW_W;
        end else if (can_rx) begin
          dec_rx    = 1'b1;
          state_nxt = RX_AR;
        end else begin
          state_nxt = AFTER_POLL;
        end
      end
      TX_AW_W: begin
        axi_awvalid = !aw_done;
        axi_wvalid  = !w_done;
        if ((aw_done || axi_awready) && (w_done || axi_wready)) state_nxt = TX_B;
      end
      TX_B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          tx_pop    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RX_AR: begin
        axi_arvalid = 1'b1;
        axi_araddr  = ADDR_RX;
        if (axi_arready) state_nxt = RX_R;
      end
      RX_R: begin
        axi_rready = 1'b1;
        if (axi_rvalid) begin
          rx_push   = axi_rresp == 2'b00;
          state_nxt = IDLE;
        end
      end
      GAP:     if (gap_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_rx    <= 1'b0;
      stat_full  <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      prio_rx    <= 1'b0;
      gap_cnt    <= 8'(GAP_LOAD);
      axi_err    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (stat_ok) begin
        stat_rx   <= axi_rdata[0];
        stat_full <= axi_rdata[3];
      end
      aw_done <= (state == TX_AW_W) && (aw_done || axi_awready);
      w_done  <= (state == TX_AW_W) && (w_done || axi_wready);
      if (dec_tx)      prio_rx <= 1'b1;
      else if (dec_rx) prio_rx <= 1'b0;
      gap_cnt <= (state == GAP) ? gap_cnt - 8'd1 : 8'(GAP_LOAD);
      if (b_err || r_err) axi_err <= 1'b1;
      else if (err_clr)   axi_err <= 1'b0;
      if (stat_ok && axi_rdata[5]) rx_overrun <= 1'b1;
      else if (err_clr)            rx_overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uartlite_stream_ctrl.sv
// Bench for uartlite_stream_ctrl: behavioural AXI-Lite UART slave plus byte-stream
// reference queues; directed table, corner sequences and a randomized phase.
module tb_uartlite_stream_ctrl;
  localparam int TXD = 4, RXD = 4, PG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, tx_valid, tx_ready, rx_valid, rx_ready, rx_overrun, axi_err, err_clr;
  logic [7:0] tx_data, rx_data;
  logic [2:0] tx_level, rx_level;
  logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [3:0] axi_awaddr, axi_araddr, axi_wstrb;
  logic [2:0] axi_awprot, axi_arprot;
  logic [31:0] axi_wdata, axi_rdata;
  logic [1:0] axi_bresp, axi_rresp;

  uartlite_stream_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .POLL_GAP(PG)) dut (
    .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_level(tx_level), .rx_level(rx_level), .rx_overrun(rx_overrun), .axi_err(axi_err),
    .err_clr(err_clr),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp)
  );

  int checks = 0, errors = 0;
  int cyc = 0, rd_cnt = 0, rx_peak = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic stat_full = 1'b0, stat_ovr = 1'b0, peak_clr = 1'b0;
  logic [7:0]  rx_src[$], exp_rx[$], got_rx[$], exp_tx[$];
  logic [35:0] obs_w[$];
  logic [3:0]  obs_aw[$];
  int kinds[$], stat_times[$];
  int tx_idx = 0, rx_idx = 0;

  // Slave: zero-wait AR/R, programmable AW/W/B latency, STAT built from its own RX source.
  int aw_c, w_c, b_c;
  logic aw_got, w_got, b_pend, aw_fire, w_fire;
  assign axi_arready = 1'b1;
  assign axi_rresp   = 2'b00;
  assign aw_fire     = axi_awvalid && axi_awready;
  assign w_fire      = axi_wvalid && axi_wready;

  always @(posedge clk) begin
    if (!rstn) begin
      axi_rvalid <= 1'b0; axi_awready <= 1'b0; axi_wready <= 1'b0; axi_bvalid <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; aw_c <= 0; w_c <= 0; b_c <= 0;
      axi_rdata <= 32'd0; axi_bresp <= 2'b00;
    end else begin
      if (axi_arvalid) begin
        axi_rvalid <= 1'b1;
        if (axi_araddr == 4'h8) begin
          axi_rdata <= {26'd0, stat_ovr, 1'b0, stat_full, 2'b00, rx_src.size() != 0};
          stat_times.push_back(cyc);
        end else begin
          rd_cnt <= rd_cnt + 1;
          kinds.push_back(0);
          if (rx_src.size() != 0) axi_rdata <= {24'd0, rx_src.pop_front()};
          else axi_rdata <= 32'd0;
        end
      end else if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;

      if (axi_awvalid && !axi_awready) begin
        if (aw_c >= aw_dly) axi_awready <= 1'b1; else aw_c <= aw_c + 1;
      end else begin axi_awready <= 1'b0; aw_c <= 0; end
      if (axi_wvalid && !axi_wready) begin
        if (w_c >= w_dly) axi_wready <= 1'b1; else w_c <= w_c + 1;
      end else begin axi_wready <= 1'b0; w_c <= 0; end

      if (aw_fire) begin obs_aw.push_back(axi_awaddr); kinds.push_back(1); aw_got <= 1'b1; end
      if (w_fire) begin obs_w.push_back({axi_wstrb, axi_wdata}); w_got <= 1'b1; end
      if ((aw_got || aw_fire) && (w_got || w_fire)) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_c <= 0;
      end
      if (b_pend && !axi_bvalid) begin
        if (b_c >= b_dly) begin axi_bvalid <= 1'b1; axi_bresp <= bresp_cfg; b_pend <= 1'b0; end
        else b_c <= b_c + 1;
      end
      if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && tx_valid && tx_ready) exp_tx.push_back(tx_data);
    if (rstn && rx_valid && rx_ready) got_rx.push_back(rx_data);
    if (peak_clr) rx_peak <= 0;
    else if (int'(rx_level) > rx_peak) rx_peak <= int'(rx_level);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int t; logic acc;
    tx_valid = 1'b1; tx_data = b; acc = 1'b0; t = 0;
    while (!acc && t < 1000) begin acc = tx_ready; @(negedge clk); t++; end
    tx_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic load_rx(input logic [7:0] b);
    rx_src.push_back(b); exp_rx.push_back(b);
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while (!(obs_w.size() == exp_tx.size() && tx_level == 0 && got_rx.size() == exp_rx.size()
             && rx_level == 0) && t < 4000) begin
      @(negedge clk); t++;
    end
    chk({nm, "_drained"}, t < 4000, 1);
  endtask

  task automatic check_tx(input string nm);
    chk({nm, "_wcount"}, obs_w.size(), exp_tx.size());
    while (tx_idx < obs_w.size() && tx_idx < exp_tx.size() && tx_idx < obs_aw.size()) begin
      chk({nm, "_wdata"}, obs_w[tx_idx], {4'b0001, 24'd0, exp_tx[tx_idx]});
      chk({nm, "_awaddr"}, obs_aw[tx_idx], 4'h4);
      tx_idx++;
    end
  endtask

  task automatic check_rx(input string nm);
    chk({nm, "_rcount"}, got_rx.size(), exp_rx.size());
    while (rx_idx < got_rx.size() && rx_idx < exp_rx.size()) begin
      chk({nm, "_rdata"}, got_rx[rx_idx], exp_rx[rx_idx]);
      rx_idx++;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       exp_ready;
    logic [2:0] exp_level;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int t, k0, rb, n;
    tbl[0] = '{1'b1, 8'h10, 1'b1, 3'd1};
    tbl[1] = '{1'b0, 8'h11, 1'b1, 3'd1};
    tbl[2] = '{1'b1, 8'h12, 1'b1, 3'd2};
    tbl[3] = '{1'b1, 8'h13, 1'b1, 3'd3};
    tbl[4] = '{1'b1, 8'h14, 1'b0, 3'd4};
    tbl[5] = '{1'b1, 8'h15, 1'b0, 3'd4};

    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_levels", {tx_level, rx_level}, 6'd0);
    chk("rst_sticky", {axi_err, rx_overrun}, 2'b00);
    chk("rst_axi_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 5'd0);
    rstn = 1'b1;
    rx_ready = 1'b1;

    // Three bytes out with the core never full.
    push(8'h41); push(8'h42); push(8'h43);
    wait_drain("tx_basic");
    check_tx("tx_basic");
    chk("tx_basic_level", tx_level, 0);

    // Core reports TX full: fill the local FIFO from the table, nothing must be written.
    stat_full = 1'b1;
    repeat (20) @(negedge clk);
    n = obs_aw.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_valid = tbl[i].v; tx_data = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_tx_ready", i), tx_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_tx_level", i), tx_level, tbl[i].exp_level);
    end
    @(negedge clk); tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("blocked_no_aw", obs_aw.size(), n);
    chk("blocked_level", tx_level, 3'd4);
    k0 = stat_times.size();
    chk("poll_period", stat_times[k0-1] - stat_times[k0-2], PG + 3);
    stat_full = 1'b0;
    wait_drain("tx_unblock");
    check_tx("tx_unblock");

    // Two RX bytes with a willing consumer.
    peak_clr = 1'b1; @(negedge clk); peak_clr = 1'b0;
    load_rx(8'h5A); load_rx(8'hA5);
    wait_drain("rx_basic");
    check_rx("rx_basic");
    chk("rx_basic_peak", rx_peak, 1);

    // Consumer stalls: RX FIFO fills and reads stop.
    rx_ready = 1'b0;
    rb = rd_cnt;
    for (int i = 0; i < 6; i++) load_rx(8'h11 * (i + 1));
    repeat (100) @(negedge clk);
    chk("rx_sat_level", rx_level, 3'd4);
    chk("rx_sat_reads", rd_cnt - rb, RXD);
    chk("rx_sat_head", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_drain("rx_release");
    check_rx("rx_release");

    // Both directions pending after reset: decisions alternate starting with TX.
    do_reset();
    stat_full = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    repeat (10) @(negedge clk);
    k0 = kinds.size();
    aw_dly = 0; w_dly = 3;
    for (int i = 0; i < 4; i++) load_rx(8'h71 + 8'(i));
    stat_full = 1'b0;
    wait_drain("alt");
    check_tx("alt"); check_rx("alt");
    chk("alt_count", kinds.size() - k0, 8);
    for (int i = 0; i < 8 && k0 + i < kinds.size(); i++)
      chk($sformatf("alt_kind%0d", i), kinds[k0+i], (i % 2 == 0) ? 1 : 0);
    w_dly = 0;

    // Error response on B, then overrun flag.
    bresp_cfg = 2'b10;
    push(8'h77);
    t = 0;
    while (!axi_err && t < 500) begin @(negedge clk); t++; end
    bresp_cfg = 2'b00;
    repeat (10) @(negedge clk);
    chk("bresp_err_sticky", axi_err, 1);
    wait_drain("bresp");
    check_tx("bresp");
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("err_clr_axi", axi_err, 0);
    stat_ovr = 1'b1;
    t = 0;
    while (!rx_overrun && t < 200) begin @(negedge clk); t++; end
    chk("overrun_set", rx_overrun, 1);
    stat_ovr = 1'b0;
    repeat (10) @(negedge clk);
    chk("overrun_sticky", rx_overrun, 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("err_clr_ovr", rx_overrun, 0);

    // Randomized traffic on both streams with random slave latencies.
    aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
    for (int i = 0; i < 600; i++) begin
      tx_valid = $urandom_range(0, 1) == 1;
      tx_data  = 8'($urandom);
      rx_ready = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 15) == 0) load_rx(8'($urandom));
      if (i % 32 == 0) stat_full = $urandom_range(0, 2) == 0;
      @(negedge clk);
    end
    tx_valid = 1'b0; rx_ready = 1'b1; stat_full = 1'b0;
    wait_drain("rand");
    check_tx("rand"); check_rx("rand");

    // Reset while waiting for a B response.
    b_dly = 20;
    push(8'h99);
    t = 0;
    while (!axi_bready && t < 500) begin @(negedge clk); t++; end
    chk("txb_reached", axi_bready, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 5'd0);
    chk("midrst_levels", {tx_level, rx_level}, 6'd0);
    chk("midrst_tx_ready", tx_ready, 1);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
